// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: control-word layout,
// forwarding-select encodings and the base RV32I opcodes.
package ctrl_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_BRANCH   = 0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    STG_ADVANCE = 2'b00,
    STG_BUBBLE  = 2'b01,
    STG_HOLD    = 2'b10
  } stage_op_e;

endpackage : ctrl_pkg

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: holds when disabled, loads zero on a
// bubble, otherwise captures its input.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  import ctrl_pkg::*;

  stage_op_e    op_s;
  logic [W-1:0] stage_d;
  logic [W-1:0] stage_q;

  // Hold has priority over bubble so a frozen pipe never loses its contents.
  always_comb begin
    op_s    = STG_ADVANCE;
    stage_d = d_i;
    if (!en_i) begin
      op_s = STG_HOLD;
    end else if (bubble_i) begin
      op_s = STG_BUBBLE;
    end else begin
      op_s = STG_ADVANCE;
    end
    case (op_s)
      STG_HOLD:    stage_d = stage_q;
      STG_BUBBLE:  stage_d = {W{1'b0}};
      STG_ADVANCE: stage_d = d_i;
      default:     stage_d = {W{1'b0}};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= {W{1'b0}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule : ctrl_stage_reg

// File: rtl/ctrl_pipe.sv
// Control-bit pipeline ID/EX -> EX/MEM -> MEM/WB with load-use and
// branch-in-ID hazard detection, bubble insertion and EX forwarding selects.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int BRANCH_IN_ID = 1,
  parameter int REG_AW       = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_stall_in,
  input  logic [CTRL_W-1:0] id_ctrl_in,
  input  logic [REG_AW-1:0] id_rs1_in,
  input  logic [REG_AW-1:0] id_rs2_in,
  input  logic [REG_AW-1:0] id_rd_in,
  input  logic              id_uses_rs2_in,
  output logic              noop_out,
  output logic              pc_write_out,
  output logic              ifid_write_out,
  output logic [1:0]        ex_aluop_out,
  output logic              ex_alusrc_out,
  output logic [1:0]        fwd_a_out,
  output logic [1:0]        fwd_b_out,
  output logic              mem_memread_out,
  output logic              mem_memwrite_out,
  output logic              wb_regwrite_out,
  output logic              wb_memtoreg_out,
  output logic [REG_AW-1:0] wb_rd_out
);

  localparam int IDEX_W  = (CTRL_W - 1) + 3 * REG_AW;
  localparam int EXMEM_W = 4 + REG_AW;
  localparam int MEMWB_W = 2 + REG_AW;
  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

  logic [IDEX_W-1:0]  idex_d,  idex_q;
  logic [EXMEM_W-1:0] exmem_d, exmem_q;
  logic [MEMWB_W-1:0] memwb_d, memwb_q;

  logic [CTRL_W-1:1]  idex_ctrl_s;
  logic [REG_AW-1:0]  idex_rs1_s, idex_rs2_s, idex_rd_s;
  logic               exmem_regwrite_s, exmem_memtoreg_s;
  logic               exmem_memread_s, exmem_memwrite_s;
  logic [REG_AW-1:0]  exmem_rd_s;
  logic               memwb_regwrite_s, memwb_memtoreg_s;
  logic [REG_AW-1:0]  memwb_rd_s;

  logic load_use_s, br_alu_s, br_load_s, hazard_s, stage_en_s;

  // True when a producer's destination feeds a source the ID instruction reads.
  function automatic logic id_reads(input logic [REG_AW-1:0] r,
                                    input logic [REG_AW-1:0] rs1,
                                    input logic [REG_AW-1:0] rs2,
                                    input logic              uses_rs2);
    return (r != REG_ZERO) && ((r == rs1) || (uses_rs2 && (r == rs2)));
  endfunction

  // Pick the youngest in-flight writer of src; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              mem_wr,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              wb_wr,
                                         input logic [REG_AW-1:0] wb_rd);
    logic [1:0] sel;
    if (mem_wr && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_wr && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  assign {idex_ctrl_s, idex_rs1_s, idex_rs2_s, idex_rd_s} = idex_q;
  assign {exmem_regwrite_s, exmem_memtoreg_s, exmem_memread_s,
          exmem_memwrite_s, exmem_rd_s} = exmem_q;
  assign {memwb_regwrite_s, memwb_memtoreg_s, memwb_rd_s} = memwb_q;

  // Load-use stall applies to every instruction type.
  always_comb begin
    load_use_s = 1'b0;
    if (idex_ctrl_s[CTRL_MEMREAD]) begin
      load_use_s = id_reads(idex_rd_s, id_rs1_in, id_rs2_in, id_uses_rs2_in);
    end else begin
      load_use_s = 1'b0;
    end
  end

  // A branch compared in ID needs its operands one stage earlier than the ALU.
  if (BRANCH_IN_ID != 0) begin : g_branch_id
    always_comb begin
      br_alu_s  = 1'b0;
      br_load_s = 1'b0;
      if (id_ctrl_in[CTRL_BRANCH]) begin
        br_alu_s  = idex_ctrl_s[CTRL_REGWRITE] &
                    id_reads(idex_rd_s, id_rs1_in, id_rs2_in, id_uses_rs2_in);
        br_load_s = exmem_memread_s &
                    id_reads(exmem_rd_s, id_rs1_in, id_rs2_in, id_uses_rs2_in);
      end else begin
        br_alu_s  = 1'b0;
        br_load_s = 1'b0;
      end
    end
  end else begin : g_branch_ex
    assign br_alu_s  = 1'b0;
    assign br_load_s = 1'b0;
  end

  assign hazard_s       = load_use_s | br_alu_s | br_load_s;
  assign stage_en_s     = ~mem_stall_in;
  assign noop_out       = hazard_s & ~mem_stall_in;
  assign pc_write_out   = ~hazard_s & ~mem_stall_in;
  assign ifid_write_out = ~hazard_s & ~mem_stall_in;

  // Next-stage payloads; the ID/EX Branch bit is consumed in ID and dropped.
  always_comb begin
    idex_d  = {id_ctrl_in[CTRL_W-1:1], id_rs1_in, id_rs2_in, id_rd_in};
    exmem_d = {idex_ctrl_s[CTRL_REGWRITE], idex_ctrl_s[CTRL_MEMTOREG],
               idex_ctrl_s[CTRL_MEMREAD], idex_ctrl_s[CTRL_MEMWRITE], idex_rd_s};
    memwb_d = {exmem_regwrite_s, exmem_memtoreg_s, exmem_rd_s};
  end

  ctrl_stage_reg #(.W(IDEX_W)) u_idex (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .en_i     (stage_en_s),
    .bubble_i (hazard_s),
    .d_i      (idex_d),
    .q_o      (idex_q)
  );

  ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .en_i     (stage_en_s),
    .bubble_i (1'b0),
    .d_i      (exmem_d),
    .q_o      (exmem_q)
  );

  ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .en_i     (stage_en_s),
    .bubble_i (1'b0),
    .d_i      (memwb_d),
    .q_o      (memwb_q)
  );

  assign fwd_a_out = fwd_sel(idex_rs1_s, exmem_regwrite_s, exmem_rd_s,
                             memwb_regwrite_s, memwb_rd_s);
  assign fwd_b_out = fwd_sel(idex_rs2_s, exmem_regwrite_s, exmem_rd_s,
                             memwb_regwrite_s, memwb_rd_s);

  assign ex_aluop_out     = idex_ctrl_s[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign ex_alusrc_out    = idex_ctrl_s[CTRL_ALUSRC];
  assign mem_memread_out  = exmem_memread_s;
  assign mem_memwrite_out = exmem_memwrite_s;
  // Writes to x0 are suppressed at the register file port.
  assign wb_regwrite_out  = memwb_regwrite_s & (memwb_rd_s != REG_ZERO);
  assign wb_memtoreg_out  = memwb_memtoreg_s;
  assign wb_rd_out        = memwb_rd_s;

endmodule : ctrl_pipe

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: instruction-level reference model,
// directed hazard scenarios and a randomized instruction stream.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_stall;
  logic [7:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_u2;

  logic       noop_o, pcw_o, ifidw_o, alusrc_o, memrd_o, memwr_o, wbrw_o, wbm2r_o;
  logic [1:0] aluop_o, fwda_o, fwdb_o;
  logic [4:0] wbrd_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] c;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ins_t;

  // pipe[0] = instruction in EX, pipe[1] = in MEM, pipe[2] = in WB
  ins_t pipe [3];

  ctrl_pipe #(.BRANCH_IN_ID(1), .REG_AW(5)) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .mem_stall_in     (mem_stall),
    .id_ctrl_in       (id_ctrl),
    .id_rs1_in        (id_rs1),
    .id_rs2_in        (id_rs2),
    .id_rd_in         (id_rd),
    .id_uses_rs2_in   (id_u2),
    .noop_out         (noop_o),
    .pc_write_out     (pcw_o),
    .ifid_write_out   (ifidw_o),
    .ex_aluop_out     (aluop_o),
    .ex_alusrc_out    (alusrc_o),
    .fwd_a_out        (fwda_o),
    .fwd_b_out        (fwdb_o),
    .mem_memread_out  (memrd_o),
    .mem_memwrite_out (memwr_o),
    .wb_regwrite_out  (wbrw_o),
    .wb_memtoreg_out  (wbm2r_o),
    .wb_rd_out        (wbrd_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  // Decoder stand-in: {RegWrite,MemtoReg,MemRead,MemWrite,ALUOp,ALUSrc,Branch}
  function automatic logic [7:0] ctrl_for(input logic [6:0] opc);
    case (opc)
      OPC_R:   return 8'b1000_1000;
      OPC_I:   return 8'b1000_1010;
      OPC_LD:  return 8'b1110_0010;
      OPC_ST:  return 8'b0001_0010;
      OPC_BEQ: return 8'b0000_0101;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit reads_src(input logic [4:0] r);
    return (r != 5'd0) && ((r == id_rs1) || (id_u2 && (r == id_rs2)));
  endfunction

  function automatic bit model_hazard();
    bit h;
    h = pipe[0].c[5] && reads_src(pipe[0].rd);
    if (id_ctrl[0]) begin
      if (pipe[0].c[7] && reads_src(pipe[0].rd)) h = 1'b1;
      if (pipe[1].c[5] && reads_src(pipe[1].rd)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].c[7] && pipe[k].rd != 5'd0 && pipe[k].rd == src)
        return (k == 1) ? FWD_MEM : FWD_WB;
    end
    return FWD_RF;
  endfunction

  task automatic check_model();
    bit h;
    h = model_hazard();
    chk("noop",      noop_o,   h && !mem_stall);
    chk("pc_write",  pcw_o,    !h && !mem_stall);
    chk("ifid_write",ifidw_o,  !h && !mem_stall);
    chk("ex_aluop",  aluop_o,  pipe[0].c[3:2]);
    chk("ex_alusrc", alusrc_o, pipe[0].c[1]);
    chk("fwd_a",     fwda_o,   model_fwd(pipe[0].rs1));
    chk("fwd_b",     fwdb_o,   model_fwd(pipe[0].rs2));
    chk("mem_read",  memrd_o,  pipe[1].c[5]);
    chk("mem_write", memwr_o,  pipe[1].c[4]);
    chk("wb_regwrite", wbrw_o, pipe[2].c[7] && pipe[2].rd != 5'd0);
    chk("wb_memtoreg", wbm2r_o, pipe[2].c[6]);
    chk("wb_rd",     wbrd_o,   pipe[2].rd);
  endtask

  task automatic model_step();
    bit h;
    h = model_hazard();
    if (!mem_stall) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = h ? ins_t'(0) : ins_t'{c: id_ctrl, rs1: id_rs1, rs2: id_rs2, rd: id_rd};
    end
  endtask

  // Present one ID instruction and check every output against the model.
  task automatic set_in(input logic [6:0] opc, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic u2, input logic st);
    id_ctrl = ctrl_for(opc);
    id_rs1 = a; id_rs2 = b; id_rd = d; id_u2 = u2; mem_stall = st;
    #1;
    check_model();
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic nop_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
    end
  endtask

  // Hold a branch in ID until it issues; returns the number of stall cycles.
  task automatic hold_branch(input logic [4:0] a, input logic [4:0] b, output int stalls);
    logic h;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(OPC_BEQ, a, b, 5'd0, 1'b1, 1'b0);
      h = noop_o;
      step();
      if (!h) break;
      stalls++;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ex_aluop"}, aluop_o, 8'd0);
    chk({tag, "_ex_alusrc"}, alusrc_o, 8'd0);
    chk({tag, "_mem_read"}, memrd_o, 8'd0);
    chk({tag, "_mem_write"}, memwr_o, 8'd0);
    chk({tag, "_wb_regwrite"}, wbrw_o, 8'd0);
    chk({tag, "_wb_memtoreg"}, wbm2r_o, 8'd0);
    chk({tag, "_wb_rd"}, wbrd_o, 8'd0);
    chk({tag, "_fwd_a"}, fwda_o, 8'd0);
    chk({tag, "_fwd_b"}, fwdb_o, 8'd0);
    chk({tag, "_noop"}, noop_o, 8'd0);
  endtask

  initial begin
    int st_cnt;
    logic [6:0] opcs [6];
    opcs[0] = 7'd0; opcs[1] = OPC_R; opcs[2] = OPC_I;
    opcs[3] = OPC_LD; opcs[4] = OPC_ST; opcs[5] = OPC_BEQ;
    for (int k = 0; k < 3; k++) pipe[k] = '0;

    rst_n = 1'b0; mem_stall = 1'b0; id_ctrl = 8'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_u2 = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("por");
    chk("por_pc_write", pcw_o, 8'd1);
    chk("por_ifid_write", ifidw_o, 8'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Load-use: ld x5 ; add x6,x5,x7
    set_in(OPC_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0); step();
    set_in(OPC_R, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0);
    chk("lu_noop", noop_o, 8'd1);
    chk("lu_pc_write", pcw_o, 8'd0);
    step();
    set_in(OPC_R, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0);
    chk("lu_bubble_aluop", aluop_o, 8'd0);
    chk("lu_bubble_noop", noop_o, 8'd0);
    step();
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("lu_fwd_a", fwda_o, 8'h01);
    step();
    nop_cycles(3);

    // Back-to-back ALU forwarding
    set_in(OPC_R, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0); step();
    set_in(OPC_R, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
    chk("alu_no_stall", noop_o, 8'd0);
    step();
    set_in(OPC_R, 5'd1, 5'd5, 5'd4, 1'b1, 1'b0);
    chk("alu_fwd_a_mem", fwda_o, 8'h02);
    chk("alu_fwd_b_mem", fwdb_o, 8'h02);
    step();
    set_in(OPC_R, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); // writer of x0
    chk("alu_fwd_a_wb", fwda_o, 8'h01);
    step();
    set_in(OPC_R, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0); step();
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("x0_fwd_a", fwda_o, 8'd0);
    chk("x0_fwd_b", fwdb_o, 8'd0);
    step();
    nop_cycles(3);

    // Branch in ID
    set_in(OPC_R, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); step();
    hold_branch(5'd3, 5'd4, st_cnt);
    chk("br_alu_stalls", st_cnt[7:0], 8'd1);
    nop_cycles(3);
    set_in(OPC_LD, 5'd1, 5'd0, 5'd3, 1'b0, 1'b0); step();
    hold_branch(5'd3, 5'd4, st_cnt);
    chk("br_load_stalls", st_cnt[7:0], 8'd2);
    nop_cycles(3);
    set_in(OPC_LD, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0); step();
    set_in(OPC_I, 5'd2, 5'd7, 5'd9, 1'b0, 1'b0);
    chk("itype_spurious_rs2", noop_o, 8'd0);
    step();
    nop_cycles(3);

    // Memory stall over a pending load-use
    set_in(OPC_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      set_in(OPC_R, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1);
      chk("mst_noop", noop_o, 8'd0);
      chk("mst_pc_write", pcw_o, 8'd0);
      chk("mst_frozen_memread", memrd_o, 8'd0);
      chk("mst_frozen_alusrc", alusrc_o, 8'd1);
      step();
    end
    set_in(OPC_R, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0);
    chk("mst_release_bubble", noop_o, 8'd1);
    step();
    set_in(OPC_R, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0);
    chk("mst_single_bubble", noop_o, 8'd0);
    step();
    nop_cycles(3);

    // Writeback: sw, ld x0, ld x9
    set_in(OPC_ST, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); step();
    set_in(OPC_LD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); step();
    set_in(OPC_LD, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0); step();
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("wb_sw_regwrite", wbrw_o, 8'd0);
    step();
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("wb_ldx0_regwrite", wbrw_o, 8'd0);
    chk("wb_ldx0_memtoreg", wbm2r_o, 8'd1);
    step();
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("wb_ld9_regwrite", wbrw_o, 8'd1);
    chk("wb_ld9_memtoreg", wbm2r_o, 8'd1);
    chk("wb_ld9_rd", wbrd_o, 8'd9);
    step();

    // Randomized instruction stream with occasional memory stalls
    for (int i = 0; i < 500; i++) begin
      logic [6:0] opc;
      opc = opcs[$urandom_range(0, 5)];
      set_in(opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)),
             (opc == OPC_R || opc == OPC_ST || opc == OPC_BEQ) ? 1'b1 : 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      step();
    end

    // Asynchronous reset with every stage occupied
    set_in(OPC_LD, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0); step();
    set_in(OPC_R, 5'd2, 5'd3, 5'd10, 1'b1, 1'b0); step();
    set_in(OPC_I, 5'd4, 5'd0, 5'd11, 1'b0, 1'b0); step();
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("pre_rst_wb_rd", wbrd_o, 8'd9);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("arst");
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    @(posedge clk); #1;
    chk("arst_hold_wb_rd", wbrd_o, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("arst_pc_write", pcw_o, 8'd1);
    chk("arst_fwd_a", fwda_o, 8'd0);
    step();
    nop_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ctrl_pipe

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Downstream consumer of the ID-stage control word in the 5-stage RISC-V core, and producer of the bubble request that feeds the decoder's NoOp input.
- Carries control bits through ID/EX, EX/MEM and MEM/WB with bubble insertion and whole-pipe freeze.
- Detects load-use and branch-in-ID hazards and generates PC/IF-ID write enables and the EX forwarding selects.
- Sits between the decoder and the datapath pipeline registers.

Parameters:
- BRANCH_IN_ID, 1: branch resolved in ID; 1 enables the extra branch stall rules.
- REG_AW, 5: register address width.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-low
- mem_stall_in  in  1  data memory busy; freezes every stage
- id_ctrl_in  in  8  raw decoder word, decoder NoOp tied low; fields {RegWrite,MemtoReg,MemRead,MemWrite,ALUOp[1:0],ALUSrc,Branch}, MSB first
- id_rs1_in  in  5  ID source 1
- id_rs2_in  in  5  ID source 2
- id_rd_in  in  5  ID destination
- id_uses_rs2_in  in  1  instruction reads rs2 (R, store, branch)
- noop_out  out  1  bubble inserted this cycle
- pc_write_out  out  1  PC update enable
- ifid_write_out  out  1  IF/ID update enable
- ex_aluop_out  out  2  ID/EX ALUOp
- ex_alusrc_out  out  1  ID/EX ALUSrc
- fwd_a_out  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b_out  out  2  EX operand B select, same encoding
- mem_memread_out  out  1  EX/MEM MemRead
- mem_memwrite_out  out  1  EX/MEM MemWrite
- wb_regwrite_out  out  1  MEM/WB RegWrite; forced 0 when wb_rd_out==0
- wb_memtoreg_out  out  1  MEM/WB MemtoReg
- wb_rd_out  out  5  MEM/WB destination

Behaviour:
Registers
- ID/EX holds ctrl[7:1], rs1, rs2, rd.
- EX/MEM holds RegWrite, MemtoReg, MemRead, MemWrite, rd.
- MEM/WB holds RegWrite, MemtoReg, rd.
- Reset (rst_i low, async): all stage registers clear to 0. Resulting outputs: every registered output 0, fwd 00, noop_out 0, pc_write_out 1, ifid_write_out 1.

Hazard (combinational from current ID inputs and stage registers)
- Match(r): r!=0 and (r==id_rs1_in or (id_uses_rs2_in and r==id_rs2_in)).
- load_use = idex.MemRead and Match(idex.rd).
- When BRANCH_IN_ID=1 and id_ctrl_in.Branch=1:
  - br_alu = idex.RegWrite and Match(idex.rd).
  - br_load = exmem.MemRead and Match(exmem.rd).
- hazard = load_use | br_alu | br_load.
- noop_out = hazard & ~mem_stall_in.
- pc_write_out = ifid_write_out = ~hazard & ~mem_stall_in.

Clock edge update
- mem_stall_in=1: all three stages hold. Takes priority over hazard; nothing advances and no bubble is inserted.
- Else, hazard=1: ID/EX loads all-zero control; its rs/rd fields are don't-care and are cleared to 0. EX/MEM and MEM/WB advance normally.
- Else: ID/EX <= ID inputs, EX/MEM <= ID/EX, MEM/WB <= EX/MEM.
- Ordering: stall 2 cycles after a load into a dependent branch (br_load follows load_use). Stall 1 cycle after an ALU op into a dependent branch.

Forwarding (combinational)
- fwd_a = 10 if exmem.RegWrite and exmem.rd!=0 and exmem.rd==idex.rs1.
- Else 01 if memwb.RegWrite and memwb.rd!=0 and memwb.rd==idex.rs1.
- Else 00.
- fwd_b uses the same rule against idex.rs2.
- EX/MEM wins over MEM/WB on a double match.

Latency
- Control word reaches ex_* 1 cycle after ID, mem_* after 2, wb_* after 3, absent stalls.

Decomposition:
- Package ctrl_pkg holds:
  - control-word field indices and width (8);
  - forward-select constants FWD_RF=00, FWD_MEM=10, FWD_WB=01;
  - opcode constants R=0110011, I=0010011, LD=0000011, ST=0100011, BEQ=1100011.
- One sub-module, ctrl_stage_reg: parameterised width, with enable (hold when 0) and bubble (load zero). Instantiated three times.
- Hazard and forwarding logic stay in the top level.

Test Plan:
- Reset: hold rst_i low mid-run with nonzero stages -> all stage outputs 0 immediately, no clock required; after release pc_write_out=1 and fwd 00.
- Load-use: ld x5; then add x6,x5,x7 in ID -> one cycle with noop_out=1 and pc_write_out=0; next cycle ex_* all 0 (bubble); fwd_a_out=01 when the add reaches EX.
- Back-to-back ALU: add x1; add x2,x1,x1 -> no stall; fwd_a_out=fwd_b_out=10. Third instruction using x1 -> 01. A rd=x0 producer never forwards.
- Branch in ID: add x3 followed by beq x3,x4 -> 1 stall cycle. ld x3 followed by beq x3 -> 2 stall cycles. I-type with id_uses_rs2_in=0 and a spurious rs2 match -> no stall.
- Memory stall: assert mem_stall_in 3 cycles during a pending load_use -> all outputs frozen, noop_out=0, pc_write_out=0; on release exactly one bubble is inserted.
- Writeback: sw passes with wb_regwrite_out=0; ld with rd=0 gives wb_regwrite_out=0; ld x9 appears at wb with regwrite=1, memtoreg=1, rd=9 exactly 3 cycles after ID.
